// File: rtl/decode_stage_pipelined.sv
// RV32I decode stage: registered decode with EX/MEM operand bypass, hazard stall, flush, illegal flag.
// Latency: one cycle from an accepted fetch beat to o_valid.
// Backpressure: outputs hold while o_valid && !i_ready; o_ready drops on stall or hold, and is forced high by flush.
package decode_stage_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0100,
      ALU_SLTU = 4'b0110,
      ALU_XOR  = 4'b1000,
      ALU_SRL  = 4'b1010,
      ALU_SRA  = 4'b1011,
      ALU_OR   = 4'b1100,
      ALU_AND  = 4'b1110
   } alu_opcode_t;

   typedef struct packed {
      logic [31:0] pc;
      alu_opcode_t alu_opcode;
      logic [31:0] alu_op1;
      logic [31:0] alu_op2;
      logic [4:0]  rd_id;
      logic        is_reg_write;
      logic        is_load;
      logic        is_store;
      logic [2:0]  load_store_type;
      logic        is_jump;
      logic        is_branch;
      logic [2:0]  branch_type;
      logic [31:0] jump_address;
      logic [31:0] store_data;
      logic        illegal;
   } dec_t;
endpackage

module decode_stage_pipelined
   import decode_stage_pkg::*;
#(
   parameter int BYPASS_EN       = 1,
   parameter int ILLEGAL_EN      = 1,
   parameter int JUMP_ADDR_ALIGN = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instruction,
   output logic [4:0]  o_rs1_id,
   output logic [4:0]  o_rs2_id,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   input  logic        i_ex_wb_valid,
   input  logic        i_ex_is_load,
   input  logic [4:0]  i_ex_rd_id,
   input  logic [31:0] i_ex_rd_data,
   input  logic        i_mem_wb_valid,
   input  logic [4:0]  i_mem_rd_id,
   input  logic [31:0] i_mem_rd_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_pc,
   output alu_opcode_t o_alu_opcode,
   output logic [31:0] o_alu_op1,
   output logic [31:0] o_alu_op2,
   output logic [4:0]  o_rd_id,
   output logic        o_is_reg_write,
   output logic        o_is_load,
   output logic        o_is_store,
   output logic [2:0]  o_load_store_type,
   output logic        o_is_jump,
   output logic        o_is_branch,
   output logic [2:0]  o_branch_type,
   output logic [31:0] o_jump_address,
   output logic [31:0] o_store_data,
   output logic        o_illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, jalr_sum;
   logic        rs1_used, rs2_used, rs1_hz, rs2_hz, stall, advance, illegal;
   dec_t        dec, q;

   assign opcode   = i_instruction[6:0];
   assign funct3   = i_instruction[14:12];
   assign funct7   = i_instruction[31:25];
   assign rs1      = i_instruction[19:15];
   assign rs2      = i_instruction[24:20];
   assign o_rs1_id = rs1;
   assign o_rs2_id = rs2;

   assign imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
   assign imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
   assign imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                   i_instruction[30:25], i_instruction[11:8], 1'b0};
   assign imm_u = {i_instruction[31:12], 12'b0};
   assign imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                   i_instruction[20], i_instruction[30:21], 1'b0};

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0)                                              return 32'd0;
      if (BYPASS_EN != 0 && i_ex_wb_valid && i_ex_rd_id == rs)    return i_ex_rd_data;
      if (BYPASS_EN != 0 && i_mem_wb_valid && i_mem_rd_id == rs)  return i_mem_rd_data;
      return rf;
   endfunction

   // With bypass only a load still in EX is unresolvable; without it any in-flight writer is.
   function automatic logic hazard(input logic [4:0] rs);
      logic ex_m, mem_m;
      ex_m  = i_ex_wb_valid && i_ex_rd_id == rs;
      mem_m = i_mem_wb_valid && i_mem_rd_id == rs;
      if (rs == 5'd0)     return 1'b0;
      if (BYPASS_EN != 0) return ex_m && i_ex_is_load;
      return ex_m || mem_m;
   endfunction

   assign rs1_val  = fwd(rs1, i_rs1_data);
   assign rs2_val  = fwd(rs2, i_rs2_data);
   assign jalr_sum = rs1_val + imm_i;

   assign rs1_used = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
   assign rs2_used = opcode inside {OP_R, OP_STORE, OP_BRANCH};
   assign rs1_hz   = rs1_used && hazard(rs1);
   assign rs2_hz   = rs2_used && hazard(rs2);
   assign stall    = i_valid && (rs1_hz || rs2_hz);
   assign advance  = !o_valid || i_ready;
   assign o_ready  = (advance && !stall) || i_flush;

   always_comb begin
      dec                 = '0;
      illegal             = 1'b0;
      dec.pc              = i_pc;
      dec.alu_opcode      = ALU_ADD;
      dec.rd_id           = i_instruction[11:7];
      dec.load_store_type = funct3;
      dec.branch_type     = funct3;
      dec.store_data      = rs2_val;
      case (opcode)
         OP_R: begin
            dec.alu_opcode   = alu_opcode_t'({funct3, i_instruction[30]});
            dec.alu_op1      = rs1_val;
            dec.alu_op2      = rs2_val;
            dec.is_reg_write = 1'b1;
            illegal          = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
         end
         OP_I: begin
            // Only shifts take funct7[5]; otherwise bit 30 is immediate data.
            if (funct3 == 3'b001 || funct3 == 3'b101)
               dec.alu_opcode = alu_opcode_t'({funct3, i_instruction[30]});
            else
               dec.alu_opcode = alu_opcode_t'({funct3, 1'b0});
            dec.alu_op1      = rs1_val;
            dec.alu_op2      = imm_i;
            dec.is_reg_write = 1'b1;
            if (funct3 == 3'b001) illegal = funct7 != 7'b0000000;
            if (funct3 == 3'b101) illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
         end
         OP_LOAD: begin
            dec.alu_op1      = rs1_val;
            dec.alu_op2      = imm_i;
            dec.is_reg_write = 1'b1;
            dec.is_load      = 1'b1;
         end
         OP_STORE: begin
            dec.alu_op1  = rs1_val;
            dec.alu_op2  = imm_s;
            dec.is_store = 1'b1;
         end
         OP_BRANCH: begin
            dec.alu_opcode   = ALU_SUB;
            dec.alu_op1      = rs1_val;
            dec.alu_op2      = rs2_val;
            dec.is_branch    = 1'b1;
            dec.jump_address = i_pc + imm_b;
         end
         OP_LUI: begin
            dec.alu_op1      = imm_u;
            dec.is_reg_write = 1'b1;
         end
         OP_AUIPC: begin
            dec.alu_op1      = i_pc;
            dec.alu_op2      = imm_u;
            dec.is_reg_write = 1'b1;
         end
         OP_JAL: begin
            dec.alu_op1      = i_pc;
            dec.alu_op2      = 32'd4;
            dec.is_reg_write = 1'b1;
            dec.is_jump      = 1'b1;
            dec.jump_address = i_pc + imm_j;
         end
         OP_JALR: begin
            dec.alu_op1      = i_pc;
            dec.alu_op2      = 32'd4;
            dec.is_reg_write = 1'b1;
            dec.is_jump      = 1'b1;
            dec.jump_address = {jalr_sum[31:1], (JUMP_ADDR_ALIGN != 0) ? 1'b0 : jalr_sum[0]};
         end
         default: illegal = 1'b1;
      endcase
      if (ILLEGAL_EN != 0 && illegal) begin
         dec.illegal      = 1'b1;
         dec.is_reg_write = 1'b0;
         dec.is_load      = 1'b0;
         dec.is_store     = 1'b0;
         dec.is_jump      = 1'b0;
         dec.is_branch    = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         q       <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (advance) begin
         o_valid <= i_valid && !stall;
         if (i_valid && !stall) q <= dec;
      end
   end

   assign o_pc              = q.pc;
   assign o_alu_opcode      = q.alu_opcode;
   assign o_alu_op1         = q.alu_op1;
   assign o_alu_op2         = q.alu_op2;
   assign o_rd_id           = q.rd_id;
   assign o_is_reg_write    = q.is_reg_write;
   assign o_is_load         = q.is_load;
   assign o_is_store        = q.is_store;
   assign o_load_store_type = q.load_store_type;
   assign o_is_jump         = q.is_jump;
   assign o_is_branch       = q.is_branch;
   assign o_branch_type     = q.branch_type;
   assign o_jump_address    = q.jump_address;
   assign o_store_data      = q.store_data;
   assign o_illegal         = q.illegal;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: hand-computed vectors checked with immediate assertions.
module tb_decode_stage_pipelined;
   import decode_stage_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_flush, i_valid, i_ready;
   logic [31:0] i_pc, i_instruction, i_rs1_data, i_rs2_data;
   logic        i_ex_wb_valid, i_ex_is_load, i_mem_wb_valid;
   logic [4:0]  i_ex_rd_id, i_mem_rd_id;
   logic [31:0] i_ex_rd_data, i_mem_rd_data;
   logic        o_ready, o_valid;
   logic [4:0]  o_rs1_id, o_rs2_id, o_rd_id;
   logic [31:0] o_pc, o_alu_op1, o_alu_op2, o_jump_address, o_store_data;
   alu_opcode_t o_alu_opcode;
   logic        o_is_reg_write, o_is_load, o_is_store, o_is_jump, o_is_branch, o_illegal;
   logic [2:0]  o_load_store_type, o_branch_type;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   decode_stage_pipelined dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
      .i_pc(i_pc), .i_instruction(i_instruction), .o_rs1_id(o_rs1_id), .o_rs2_id(o_rs2_id),
      .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .i_ex_wb_valid(i_ex_wb_valid), .i_ex_is_load(i_ex_is_load), .i_ex_rd_id(i_ex_rd_id),
      .i_ex_rd_data(i_ex_rd_data), .i_mem_wb_valid(i_mem_wb_valid), .i_mem_rd_id(i_mem_rd_id),
      .i_mem_rd_data(i_mem_rd_data), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
      .o_alu_opcode(o_alu_opcode), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
      .o_rd_id(o_rd_id), .o_is_reg_write(o_is_reg_write), .o_is_load(o_is_load),
      .o_is_store(o_is_store), .o_load_store_type(o_load_store_type), .o_is_jump(o_is_jump),
      .o_is_branch(o_is_branch), .o_branch_type(o_branch_type),
      .o_jump_address(o_jump_address), .o_store_data(o_store_data), .o_illegal(o_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
      i_valid       = 1'b1;
      i_pc          = pc;
      i_instruction = instr;
   endtask

   task automatic clear_fwd();
      i_ex_wb_valid  = 1'b0;
      i_ex_is_load   = 1'b0;
      i_ex_rd_id     = 5'd0;
      i_ex_rd_data   = 32'd0;
      i_mem_wb_valid = 1'b0;
      i_mem_rd_id    = 5'd0;
      i_mem_rd_data  = 32'd0;
   endtask

   initial begin
      i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_pc = 32'd0; i_instruction = 32'd0; i_rs1_data = 32'd0; i_rs2_data = 32'd0;
      clear_fwd();
      #2;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_pc", o_pc, 32'd0);
      chk("rst_op1", o_alu_op1, 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      tick();
      i_rst_n = 1'b1;

      // addi x1,x0,-1
      feed(32'h100, 32'hFFF00093);
      #1;
      chk("addi_ready", 32'(o_ready), 32'd1);
      tick();
      chk("addi_valid", 32'(o_valid), 32'd1);
      chk("addi_op", 32'(o_alu_opcode), 32'(ALU_ADD));
      chk("addi_op1", o_alu_op1, 32'd0);
      chk("addi_op2", o_alu_op2, 32'hFFFFFFFF);
      chk("addi_rd", 32'(o_rd_id), 32'd1);
      chk("addi_wr", 32'(o_is_reg_write), 32'd1);
      chk("addi_pc", o_pc, 32'h100);

      // add x6,x5,x5 behind a load to x5 in EX
      feed(32'h104, 32'h00528333);
      i_ex_wb_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_rd_id = 5'd5; i_ex_rd_data = 32'h9999;
      #1;
      chk("lu_ready", 32'(o_ready), 32'd0);
      chk("lu_rs1_id", 32'(o_rs1_id), 32'd5);
      tick();
      chk("lu_bubble", 32'(o_valid), 32'd0);
      chk("lu_hold_pc", o_pc, 32'h100);
      clear_fwd();
      i_mem_wb_valid = 1'b1; i_mem_rd_id = 5'd5; i_mem_rd_data = 32'h1234;
      i_rs1_data = 32'hDEAD; i_rs2_data = 32'hDEAD;
      #1;
      chk("lu_ready2", 32'(o_ready), 32'd1);
      tick();
      chk("lu_valid", 32'(o_valid), 32'd1);
      chk("lu_op1", o_alu_op1, 32'h1234);
      chk("lu_op2", o_alu_op2, 32'h1234);
      chk("lu_rd", 32'(o_rd_id), 32'd6);

      // sub x4,x3,x3: EX beats MEM beats regfile
      feed(32'h108, 32'h40318233);
      clear_fwd();
      i_ex_wb_valid = 1'b1; i_ex_rd_id = 5'd3; i_ex_rd_data = 32'hAAAA;
      i_mem_wb_valid = 1'b1; i_mem_rd_id = 5'd3; i_mem_rd_data = 32'hBBBB;
      i_rs1_data = 32'hCCCC; i_rs2_data = 32'hCCCC;
      tick();
      chk("prio_op", 32'(o_alu_opcode), 32'(ALU_SUB));
      chk("prio_op1", o_alu_op1, 32'hAAAA);
      chk("prio_op2", o_alu_op2, 32'hAAAA);

      // add x7,x0,x0 with EX load claiming x0: no stall, operands zero
      feed(32'h10C, 32'h000003B3);
      clear_fwd();
      i_ex_wb_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_rd_id = 5'd0; i_ex_rd_data = 32'd5;
      #1;
      chk("x0_ready", 32'(o_ready), 32'd1);
      tick();
      chk("x0_valid", 32'(o_valid), 32'd1);
      chk("x0_op1", o_alu_op1, 32'd0);
      chk("x0_op2", o_alu_op2, 32'd0);

      // backpressure for 3 cycles, addi x8,x0,5 waiting
      clear_fwd();
      i_ready = 1'b0;
      feed(32'h110, 32'h00500413);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 32'(o_ready), 32'd0);
         tick();
         chk("bp_valid", 32'(o_valid), 32'd1);
         chk("bp_pc", o_pc, 32'h10C);
         chk("bp_rd", 32'(o_rd_id), 32'd7);
      end
      i_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(o_ready), 32'd1);
      tick();
      chk("bp_next_valid", 32'(o_valid), 32'd1);
      chk("bp_next_pc", o_pc, 32'h110);
      chk("bp_next_op2", o_alu_op2, 32'd5);
      chk("bp_next_rd", 32'(o_rd_id), 32'd8);

      // flush with held beat and incoming addi x9,x0,7
      i_ready = 1'b0;
      feed(32'h114, 32'h00700493);
      i_flush = 1'b1;
      #1;
      chk("fl_ready", 32'(o_ready), 32'd1);
      tick();
      chk("fl_valid", 32'(o_valid), 32'd0);
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      tick();
      chk("fl_gone", 32'(o_valid), 32'd0);
      chk("fl_pc", o_pc, 32'h110);

      // ecall is illegal
      feed(32'h118, 32'h00000073);
      tick();
      chk("ill_valid", 32'(o_valid), 32'd1);
      chk("ill_flag", 32'(o_illegal), 32'd1);
      chk("ill_wr", 32'(o_is_reg_write), 32'd0);

      // beq x0,x0,-8
      feed(32'h200, 32'hFE000CE3);
      tick();
      chk("beq_branch", 32'(o_is_branch), 32'd1);
      chk("beq_target", o_jump_address, 32'h1F8);
      chk("beq_op", 32'(o_alu_opcode), 32'(ALU_SUB));
      chk("beq_illegal", 32'(o_illegal), 32'd0);
      chk("beq_wr", 32'(o_is_reg_write), 32'd0);

      // jalr x1,5(x2): odd target gets bit 0 cleared
      feed(32'h300, 32'h005100E7);
      i_rs1_data = 32'h1000; i_rs2_data = 32'h0;
      tick();
      chk("jalr_jump", 32'(o_is_jump), 32'd1);
      chk("jalr_target", o_jump_address, 32'h1004);
      chk("jalr_op1", o_alu_op1, 32'h300);
      chk("jalr_op2", o_alu_op2, 32'd4);

      // lui x2,0x12345
      feed(32'h304, 32'h12345137);
      tick();
      chk("lui_op1", o_alu_op1, 32'h12345000);
      chk("lui_op2", o_alu_op2, 32'd0);

      // mul encoding (funct7=0000001) is illegal
      feed(32'h308, 32'h02000033);
      tick();
      chk("r7_illegal", 32'(o_illegal), 32'd1);
      chk("r7_wr", 32'(o_is_reg_write), 32'd0);

      // sw x5,8(x2)
      feed(32'h30C, 32'h00512423);
      i_rs1_data = 32'h1000; i_rs2_data = 32'hCAFE;
      tick();
      chk("sw_store", 32'(o_is_store), 32'd1);
      chk("sw_op1", o_alu_op1, 32'h1000);
      chk("sw_op2", o_alu_op2, 32'd8);
      chk("sw_data", o_store_data, 32'hCAFE);
      chk("sw_type", 32'(o_load_store_type), 32'd2);
      chk("sw_wr", 32'(o_is_reg_write), 32'd0);

      i_valid = 1'b0;
      tick();
      chk("idle_valid", 32'(o_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Registered RV32I instruction-decode pipeline stage that replaces the purely combinational decoder.
- Sits between fetch and execute, with valid/ready handshakes on both sides.
- Adds operand bypass from the EX and MEM stages, load-use and RAW stall generation, pipeline flush and illegal-instruction flagging.
- Decoded fields are held in an output register: one stage of latency.

Parameters:
- BYPASS_EN, default 1: 1 forwards EX/MEM results to operands; 0 stalls on any RAW hazard against EX or MEM.
- ILLEGAL_EN, default 1: 1 enables o_illegal; 0 ties o_illegal to 0.
- JUMP_ADDR_ALIGN, default 1: 1 clears bit 0 of the JALR target.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_flush  in  1  discard held and incoming instruction
- i_valid  in  1  fetch beat valid
- o_ready  out  1  stage accepts beat
- i_pc  in  32  instruction PC
- i_instruction  in  32  instruction word
- o_rs1_id  out  5  regfile read address 1 (combinational from i_instruction)
- o_rs2_id  out  5  regfile read address 2
- i_rs1_data  in  32  regfile data 1
- i_rs2_data  in  32  regfile data 2
- i_ex_wb_valid  in  1  EX holds a reg-writing instruction
- i_ex_is_load  in  1  EX instruction is a load
- i_ex_rd_id  in  5  EX destination register
- i_ex_rd_data  in  32  EX result
- i_mem_wb_valid  in  1  MEM holds a reg-writing instruction
- i_mem_rd_id  in  5  MEM destination register
- i_mem_rd_data  in  32  MEM result
- o_valid  out  1  decoded beat valid
- i_ready  in  1  EX accepts beat
- o_pc  out  32  registered PC
- o_alu_opcode  out  alu_opcode_t  ALU op
- o_alu_op1, o_alu_op2  out  32  ALU operands
- o_rd_id  out  5  destination register
- o_is_reg_write  out  1  write-back enable
- o_is_load  out  1  load
- o_is_store  out  1  store
- o_load_store_type  out  3  funct3 of load/store
- o_is_jump  out  1  JAL/JALR
- o_is_branch  out  1  branch
- o_branch_type  out  3  funct3 of branch
- o_jump_address  out  32  branch/jump target
- o_store_data  out  32  forwarded rs2 value for stores
- o_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0 and every registered output=0. o_ready reflects its combinational equation immediately: it is 1 after reset when no hazard is present.
- Handshake:
  - advance = !o_valid || i_ready.
  - o_ready = advance && !stall || i_flush.
  - A beat transfers when i_valid && o_ready.
- Output register update on each edge where advance=1:
  - o_valid <= i_valid && !stall && !i_flush.
  - Data fields load from decode only when that new o_valid=1; otherwise they hold their previous values.
- Backpressure: when advance=0, all outputs hold stable.
- Flush: highest priority. At the next edge o_valid=0 and the input beat is consumed and discarded.
- Operand source per rs:
  - rs==0 gives 0.
  - Otherwise the source is EX match, then MEM match, then the regfile, in that priority.
  - A match requires the stage's wb_valid and rd_id==rs.
  - When BYPASS_EN=0, only the regfile is used.
- rs usage:
  - rs1 is used by R, I, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
- Stall (combinational): requires i_valid, an rs that is used, and rs!=0, plus one of:
  - BYPASS_EN=1: an EX match with i_ex_is_load=1.
  - BYPASS_EN=0: any EX or MEM match.
- During a stall: o_ready=0. If advance=1 a bubble is inserted (o_valid <= 0). The same instruction re-decodes with fresh forwarding each cycle.
- Decode per opcode:
  - R-type: op {funct3,funct7[5]}.
  - I-type: op {funct3,funct7[5]} only for funct3 001/101; otherwise {funct3,0}, so ADDI with a negative immediate decodes as ADD.
  - LOAD and STORE: ADD rs1 + imm.
  - BRANCH: SUB rs1, rs2, target pc+Bimm.
  - LUI: Uimm+0.
  - AUIPC: pc+Uimm.
  - JAL: pc+4, target pc+Jimm.
  - JALR: pc+4, target forwarded rs1+Iimm, with bit0 cleared if JUMP_ADDR_ALIGN=1.
  - Immediates are sign-extended from bit 31. Arithmetic is 32-bit modulo (wrap-around, no carry out).
- Illegal when ILLEGAL_EN=1: o_illegal=1 and o_is_reg_write/o_is_load/o_is_store/o_is_jump/o_is_branch=0. Triggered by:
  - any unknown opcode;
  - SYSTEM;
  - R-type with funct7 other than 0000000/0100000;
  - SLLI/SRLI/SRAI with an invalid funct7.

Test Plan:
- Reset, then ADDI x1,x0,-1 (0xFFF00093) at pc 0x100 -> next edge o_valid=1, op ADD, op1=0, op2=0xFFFFFFFF, rd=1, reg_write=1, o_pc=0x100.
- EX load rd=5, input add x6,x5,x5 (0x00528333) -> o_ready=0 and a bubble for one cycle; next cycle with EX clear and MEM rd=5 data 0x1234 -> op1=op2=0x1234.
- EX rd=3 0xAAAA, MEM rd=3 0xBBBB, regfile 0xCCCC, sub x4,x3,x3 (0x40318233) -> op1=op2=0xAAAA, op SUB; separately EX rd=0 data 5 with rs=x0 -> operand 0.
- o_valid=1 with i_ready=0 for 3 cycles -> outputs stable and o_ready=0; then i_ready=1 -> the held beat retires and the next instruction follows in order.
- i_flush=1 while o_valid=1 and i_valid=1 -> next cycle o_valid=0, input consumed and never emitted.
- 0x00000073 -> o_illegal=1, reg_write=0; beq x0,x0,-8 (0xFE000CE3) at pc 0x200 -> o_is_branch=1, o_jump_address=0x1F8.
